sfm_stream_sched: RTL and testbench

SFM_STREAM_SCHED -- requirements
Module: sfm_stream_sched

---
 rtl/hci_package.sv | 29 ++
 rtl/sfm_stream_sched_pkg.sv | 21 ++
 rtl/sfm_stream_sched_if.sv | 30 +++
 rtl/sfm_stream_sched.sv | 214 +++++++++++++++++++++
 tb/tb_sfm_stream_sched.sv | 381 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hci_package.sv
// Streamer command/flag types shared by the scheduler and the HCI streamers.
// Contents:
//   hci_streamer_addressgen_ctrl_t - address generator programming fields
//   hci_streamer_ctrl_t            - req_start strobe plus address generator fields
//   hci_streamer_flags_t           - streamer status (ready_start, done)
package hci_package;

    typedef struct packed {
        logic [31:0] base_addr;
        logic [31:0] tot_len;
        logic [31:0] d0_len;
        logic [31:0] d0_stride;
        logic [31:0] d1_len;
        logic [31:0] d1_stride;
        logic [31:0] d2_stride;
        logic [1:0]  dim_enable_1h;
    } hci_streamer_addressgen_ctrl_t;

    typedef struct packed {
        logic                          req_start;
        hci_streamer_addressgen_ctrl_t addressgen_ctrl;
    } hci_streamer_ctrl_t;

    typedef struct packed {
        logic ready_start;
        logic done;
    } hci_streamer_flags_t;

endpackage

// File: rtl/sfm_stream_sched_pkg.sv
// Shared softmax-engine definitions used by the row scheduler.
// Contents:
//   SFM_DATA_WIDTH    - default TCDM word width in bits
//   SFM_BPW           - bytes per TCDM word (DATA_WIDTH/8)
//   sfm_sched_state_e - scheduler FSM states
package sfm_stream_sched_pkg;

    localparam int unsigned SFM_DATA_WIDTH = 128;
    localparam int unsigned SFM_BPW        = SFM_DATA_WIDTH / 8;

    typedef enum logic [2:0] {
        StIdle,
        StAccStart,
        StAccWait,
        StNormStart,
        StNormWait,
        StNextRow,
        StFinish
    } sfm_sched_state_e;

endpackage

// File: rtl/sfm_stream_sched_if.sv
// Streamer handshake bundle between the scheduler and the in/out HCI streamers.
// Signals (named from the scheduler's point of view):
//   in_ctrl_o / out_ctrl_o   - commands to the input and output streamers
//   in_flags_i / out_flags_i - status from the input and output streamers
// Modports:
//   master - scheduler side (drives ctrl, samples flags)
//   slave  - streamer side (samples ctrl, drives flags)
interface sfm_stream_sched_if;
    import hci_package::*;

    hci_streamer_ctrl_t  in_ctrl_o;
    hci_streamer_ctrl_t  out_ctrl_o;
    hci_streamer_flags_t in_flags_i;
    hci_streamer_flags_t out_flags_i;

    modport master (
        output in_ctrl_o,
        output out_ctrl_o,
        input  in_flags_i,
        input  out_flags_i
    );

    modport slave (
        input  in_ctrl_o,
        input  out_ctrl_o,
        output in_flags_i,
        output out_flags_i
    );

endinterface

// File: rtl/sfm_stream_sched.sv
// Softmax row scheduler: for each row runs an ACC pass (input streamer only,
// datapath reduces max/sum) followed by a NORM pass (input and output streamers
// together), then steps both row addresses by the row stride.
// Ports:
//   clk_i, rst_i (sync, active-high), clear_i (soft clear, same effect as rst_i)
//   start_i                      - job start pulse, ignored while busy
//   in_base_i, out_base_i        - row-0 byte addresses
//   row_len_i, row_stride_i      - row length and row-to-row distance in bytes
//   n_rows_i                     - number of rows
//   strm (sfm_stream_sched_if.master) - in/out streamer commands and flags
//   dp_acc_done_i                - datapath reduction finished
//   dp_phase_o                   - 0 = ACC pass, 1 = NORM pass
//   busy_o, done_o               - job active / 1-cycle job completion pulse
//   row_idx_o                    - current row index
//   perf_cycles_o                - busy-cycle counter, only with SFM_STREAM_SCHED_PERF_EN
// Build option: define SFM_STREAM_SCHED_PERF_EN to add perf_cycles_o.
module sfm_stream_sched
    import hci_package::*;
    import sfm_stream_sched_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = 128,
    parameter int unsigned ADDR_WIDTH    = 32,
    parameter int unsigned ROW_CNT_WIDTH = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     clear_i,
    input  logic                     start_i,
    input  logic [ADDR_WIDTH-1:0]    in_base_i,
    input  logic [ADDR_WIDTH-1:0]    out_base_i,
    input  logic [31:0]              row_len_i,
    input  logic [31:0]              row_stride_i,
    input  logic [ROW_CNT_WIDTH-1:0] n_rows_i,
    sfm_stream_sched_if.master       strm,
    input  logic                     dp_acc_done_i,
    output logic                     dp_phase_o,
    output logic                     busy_o,
    output logic                     done_o,
    output logic [ROW_CNT_WIDTH-1:0] row_idx_o
`ifdef SFM_STREAM_SCHED_PERF_EN
    ,
    output logic [31:0]              perf_cycles_o
`endif
);

    localparam int unsigned Bpw     = DATA_WIDTH / 8;
    localparam int unsigned BpwLog2 = $clog2(Bpw);

    // Join of two sticky done events. Returns {all_done, a_next, b_next}.
    // Events are dropped while clr is high; the pair self-clears once joined
    // so the next wait always starts from an empty pair.
    function automatic logic [2:0] sfm_done_join(input logic clr,
                                                 input logic a_q,
                                                 input logic b_q,
                                                 input logic a_ev,
                                                 input logic b_ev);
        logic a_seen;
        logic b_seen;
        logic joined;
        a_seen = a_q | a_ev;
        b_seen = b_q | b_ev;
        joined = !clr && a_seen && b_seen;
        return {joined, !clr && !joined && a_seen, !clr && !joined && b_seen};
    endfunction

    sfm_sched_state_e         state_q, state_d;
    logic [ROW_CNT_WIDTH-1:0] row_idx_q, row_idx_d;
    logic [ROW_CNT_WIDTH-1:0] n_rows_q, n_rows_d;
    logic [ADDR_WIDTH-1:0]    in_addr_q, in_addr_d;
    logic [ADDR_WIDTH-1:0]    out_addr_q, out_addr_d;
    logic [ADDR_WIDTH-1:0]    stride_q, stride_d;
    logic [31:0]              row_len_q, row_len_d;
    logic                     sticky_a_q, sticky_a_d;
    logic                     sticky_b_q, sticky_b_d;

    logic in_req;
    logic out_req;
    logic in_wait;
    logic ev_b;
    logic all_done;

    // Only the done flags matter to the scheduler.
    logic unused_flags;
    assign unused_flags = strm.in_flags_i.ready_start ^ strm.out_flags_i.ready_start;

    always_comb begin
        state_d    = state_q;
        row_idx_d  = row_idx_q;
        n_rows_d   = n_rows_q;
        in_addr_d  = in_addr_q;
        out_addr_d = out_addr_q;
        stride_d   = stride_q;
        row_len_d  = row_len_q;
        in_req     = 1'b0;
        out_req    = 1'b0;
        dp_phase_o = 1'b0;
        done_o     = 1'b0;
        busy_o     = (state_q != StIdle);

        // One sticky pair serves both waits: slot a is always the input
        // streamer, slot b is the reduction in ACC and the output streamer in NORM.
        in_wait = (state_q == StAccWait) || (state_q == StNormWait);
        ev_b    = (state_q == StNormWait) ? strm.out_flags_i.done : dp_acc_done_i;
        {all_done, sticky_a_d, sticky_b_d} = sfm_done_join(!in_wait, sticky_a_q, sticky_b_q,
                                                           strm.in_flags_i.done, ev_b);

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    row_idx_d  = '0;
                    n_rows_d   = n_rows_i;
                    in_addr_d  = in_base_i;
                    out_addr_d = out_base_i;
                    stride_d   = ADDR_WIDTH'(row_stride_i);
                    row_len_d  = row_len_i;
                    state_d    = (n_rows_i == '0 || row_len_i == '0) ? StFinish : StAccStart;
                end
            end
            StAccStart: begin
                in_req  = 1'b1;
                state_d = StAccWait;
            end
            StAccWait: begin
                if (all_done) state_d = StNormStart;
            end
            StNormStart: begin
                in_req     = 1'b1;
                out_req    = 1'b1;
                dp_phase_o = 1'b1;
                state_d    = StNormWait;
            end
            StNormWait: begin
                dp_phase_o = 1'b1;
                if (all_done) state_d = StNextRow;
            end
            StNextRow: begin
                row_idx_d  = row_idx_q + ROW_CNT_WIDTH'(1);
                in_addr_d  = in_addr_q + stride_q;
                out_addr_d = out_addr_q + stride_q;
                state_d    = (row_idx_d == n_rows_q) ? StFinish : StAccStart;
            end
            StFinish: begin
                done_o  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Row-invariant command fields; only req_start and base_addr differ per stream.
    always_comb begin
        strm.in_ctrl_o  = '0;
        strm.out_ctrl_o = '0;

        strm.in_ctrl_o.req_start                 = in_req;
        strm.in_ctrl_o.addressgen_ctrl.base_addr = 32'(in_addr_q);
        strm.in_ctrl_o.addressgen_ctrl.tot_len   = row_len_q >> BpwLog2;
        strm.in_ctrl_o.addressgen_ctrl.d0_len    = row_len_q;
        strm.in_ctrl_o.addressgen_ctrl.d0_stride = 32'(Bpw);

        strm.out_ctrl_o.req_start                 = out_req;
        strm.out_ctrl_o.addressgen_ctrl.base_addr = 32'(out_addr_q);
        strm.out_ctrl_o.addressgen_ctrl.tot_len   = row_len_q >> BpwLog2;
        strm.out_ctrl_o.addressgen_ctrl.d0_len    = row_len_q;
        strm.out_ctrl_o.addressgen_ctrl.d0_stride = 32'(Bpw);
    end

    assign row_idx_o = row_idx_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            state_q    <= StIdle;
            row_idx_q  <= '0;
            n_rows_q   <= '0;
            in_addr_q  <= '0;
            out_addr_q <= '0;
            stride_q   <= '0;
            row_len_q  <= '0;
            sticky_a_q <= 1'b0;
            sticky_b_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            row_idx_q  <= row_idx_d;
            n_rows_q   <= n_rows_d;
            in_addr_q  <= in_addr_d;
            out_addr_q <= out_addr_d;
            stride_q   <= stride_d;
            row_len_q  <= row_len_d;
            sticky_a_q <= sticky_a_d;
            sticky_b_q <= sticky_b_d;
        end
    end

`ifdef SFM_STREAM_SCHED_PERF_EN
    logic [31:0] perf_q, perf_d;

    always_comb begin
        perf_d = perf_q;
        if (state_q == StIdle) begin
            if (start_i) perf_d = '0;
        end else if (perf_q != 32'hFFFF_FFFF) begin
            perf_d = perf_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) perf_q <= '0;
        else                  perf_q <= perf_d;
    end

    assign perf_cycles_o = perf_q;
`endif

endmodule

// File: tb/tb_sfm_stream_sched.sv
// Self-checking bench for sfm_stream_sched: directed timing scenarios plus
// randomized jobs checked by a scoreboard fed from a row-level reference model.
module tb_sfm_stream_sched;
    import hci_package::*;

    logic        clk = 1'b0;
    logic        rst, clear, start;
    logic [31:0] in_base, out_base, row_len, row_stride;
    logic [15:0] n_rows;
    logic        dp_phase, busy, done;
    logic [15:0] row_idx;
    logic        d_in, d_out, d_acc;   // directed flag drives
    logic        r_in, r_out, r_acc;   // responder flag drives
    logic        dp_acc_done;
`ifdef SFM_STREAM_SCHED_PERF_EN
    logic [31:0] perf_cycles;
`endif

    int n_vec = 0;
    int n_err = 0;
    int done_seen = 0;
    bit mon_en = 1'b0;
    bit auto_resp = 1'b0;

    sfm_stream_sched_if strm ();

    assign strm.in_flags_i  = {1'b1, d_in | r_in};
    assign strm.out_flags_i = {1'b1, d_out | r_out};
    assign dp_acc_done      = d_acc | r_acc;

    always #5 clk = ~clk;

    sfm_stream_sched #(
        .DATA_WIDTH    (128),
        .ADDR_WIDTH    (32),
        .ROW_CNT_WIDTH (16)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .clear_i       (clear),
        .start_i       (start),
        .in_base_i     (in_base),
        .out_base_i    (out_base),
        .row_len_i     (row_len),
        .row_stride_i  (row_stride),
        .n_rows_i      (n_rows),
        .strm          (strm),
        .dp_acc_done_i (dp_acc_done),
        .dp_phase_o    (dp_phase),
        .busy_o        (busy),
        .done_o        (done),
        .row_idx_o     (row_idx)
`ifdef SFM_STREAM_SCHED_PERF_EN
        ,
        .perf_cycles_o (perf_cycles)
`endif
    );

    typedef struct packed {
        logic        is_done;
        logic        in_req;
        logic        out_req;
        logic        phase;
        logic [31:0] in_addr;
        logic [31:0] out_addr;
        logic [31:0] tot_len;
        logic [31:0] d0_len;
        logic [31:0] d0_stride;
        logic        nonzero;
    } ev_t;

    ev_t exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Advance to the next falling edge and drop all single-cycle pulses.
    task automatic tick();
        @(negedge clk);
        start = 1'b0;
        clear = 1'b0;
        d_in  = 1'b0;
        d_out = 1'b0;
        d_acc = 1'b0;
    endtask

    task automatic set_cfg(input logic [31:0] ib, input logic [31:0] ob, input logic [31:0] len,
                           input logic [31:0] stride, input int n);
        in_base    = ib;
        out_base   = ob;
        row_len    = len;
        row_stride = stride;
        n_rows     = 16'(n);
    endtask

    // Reference model: a job is, per row, one ACC command on the input stream
    // then one NORM command on both streams, rows spaced by stride (mod 2^32);
    // a job with no rows or empty rows issues nothing. A done event closes it.
    task automatic push_job(input logic [31:0] ib, input logic [31:0] ob, input logic [31:0] len,
                            input logic [31:0] stride, input int n);
        ev_t         e;
        logic [31:0] ia, oa;
        ia = ib;
        oa = ob;
        if (n != 0 && len != 0) begin
            for (int r = 0; r < n; r++) begin
                e = '0;
                e.in_req = 1'b1;
                e.in_addr = ia;
                e.tot_len = len / 16;
                e.d0_len = len;
                e.d0_stride = 32'd16;
                exp_q.push_back(e);
                e.out_req = 1'b1;
                e.phase = 1'b1;
                e.out_addr = oa;
                exp_q.push_back(e);
                ia = ia + stride;
                oa = oa + stride;
            end
        end
        e = '0;
        e.is_done = 1'b1;
        exp_q.push_back(e);
    endtask

    // Monitor: every command or done pulse must match the head of the queue.
    initial begin
        ev_t act, e;
        forever begin
            @(negedge clk);
            if (mon_en && (done || strm.in_ctrl_o.req_start || strm.out_ctrl_o.req_start)) begin
                act = '0;
                if (done) begin
                    act.is_done = 1'b1;
                    done_seen++;
                end
                if (strm.in_ctrl_o.req_start || strm.out_ctrl_o.req_start) begin
                    act.in_req    = strm.in_ctrl_o.req_start;
                    act.out_req   = strm.out_ctrl_o.req_start;
                    act.phase     = dp_phase;
                    act.in_addr   = strm.in_ctrl_o.addressgen_ctrl.base_addr;
                    act.out_addr  = strm.out_ctrl_o.req_start ?
                                    strm.out_ctrl_o.addressgen_ctrl.base_addr : 32'h0;
                    act.tot_len   = strm.in_ctrl_o.addressgen_ctrl.tot_len;
                    act.d0_len    = strm.in_ctrl_o.addressgen_ctrl.d0_len;
                    act.d0_stride = strm.in_ctrl_o.addressgen_ctrl.d0_stride;
                    act.nonzero   = |{strm.in_ctrl_o.addressgen_ctrl.d1_len,
                                      strm.in_ctrl_o.addressgen_ctrl.d1_stride,
                                      strm.in_ctrl_o.addressgen_ctrl.d2_stride,
                                      strm.in_ctrl_o.addressgen_ctrl.dim_enable_1h};
                end
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL scoreboard: unexpected event done=%0b in=%0b out=%0b ia=%h",
                             act.is_done, act.in_req, act.out_req, act.in_addr);
                end else begin
                    e = exp_q.pop_front();
                    if (act !== e) begin
                        n_err++;
                        $display({"FAIL scoreboard: got done=%0b in=%0b out=%0b ph=%0b ia=%h oa=%h ",
                                  "tot=%0d d0=%0d st=%0d nz=%0b, expected done=%0b in=%0b out=%0b ",
                                  "ph=%0b ia=%h oa=%h tot=%0d d0=%0d st=%0d nz=%0b"},
                                 act.is_done, act.in_req, act.out_req, act.phase, act.in_addr,
                                 act.out_addr, act.tot_len, act.d0_len, act.d0_stride, act.nonzero,
                                 e.is_done, e.in_req, e.out_req, e.phase, e.in_addr, e.out_addr,
                                 e.tot_len, e.d0_len, e.d0_stride, e.nonzero);
                    end
                end
            end
        end
    end

    // Streamer/datapath responder: answers each command after a random delay.
    initial begin
        int cd_in, cd_out, cd_acc;
        cd_in = 0; cd_out = 0; cd_acc = 0;
        r_in = 1'b0; r_out = 1'b0; r_acc = 1'b0;
        forever begin
            @(negedge clk);
            r_in = 1'b0; r_out = 1'b0; r_acc = 1'b0;
            if (cd_in > 0) begin cd_in--; if (cd_in == 0) r_in = 1'b1; end
            if (cd_out > 0) begin cd_out--; if (cd_out == 0) r_out = 1'b1; end
            if (cd_acc > 0) begin cd_acc--; if (cd_acc == 0) r_acc = 1'b1; end
            if (auto_resp && strm.in_ctrl_o.req_start) begin
                cd_in = int'($urandom_range(1, 6));
                if (dp_phase) cd_out = int'($urandom_range(1, 6));
                else          cd_acc = int'($urandom_range(1, 6));
            end
        end
    end

    task automatic run_job(input logic [31:0] ib, input logic [31:0] ob, input logic [31:0] len,
                           input logic [31:0] stride, input int n, input bit noise);
        int busy_cnt;
        int done_before;
        bit got;
        busy_cnt = 0;
        got = 1'b0;
        mon_en = 1'b1;
        auto_resp = 1'b1;
        tick();
        done_before = done_seen;
        set_cfg(ib, ob, len, stride, n);
        start = 1'b1;
        push_job(ib, ob, len, stride, n);
        for (int c = 0; c < 3000 && !got; c++) begin
            tick();
            if (busy) busy_cnt++;
            if (done) got = 1'b1;
            else if (noise && busy && $urandom_range(0, 7) == 0) begin
                // Start while busy must be ignored; the expected sequence is unchanged.
                set_cfg($urandom, $urandom, $urandom, $urandom, int'($urandom_range(1, 9)));
                start = 1'b1;
            end
        end
        if (!got) $display("FAIL job_timeout: got no done_o, expected done_o within 3000 cycles");
        tick();
        check("job_done_count", 64'(done_seen - done_before), 64'd1);
        check("job_queue_left", 64'(exp_q.size()), 64'd0);
        check("job_idle_busy", 64'(busy), 64'd0);
`ifdef SFM_STREAM_SCHED_PERF_EN
        check("perf_cycles", 64'(perf_cycles), 64'(busy_cnt));
`endif
        exp_q.delete();
        mon_en = 1'b0;
        auto_resp = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; clear = 1'b0; start = 1'b0;
        d_in = 1'b0; d_out = 1'b0; d_acc = 1'b0;
        set_cfg(32'h0, 32'h0, 32'h0, 32'h0, 0);
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_phase", 64'(dp_phase), 64'd0);
        check("rst_reqs", 64'({strm.in_ctrl_o.req_start, strm.out_ctrl_o.req_start}), 64'd0);
        check("rst_row_idx", 64'(row_idx), 64'd0);
`ifdef SFM_STREAM_SCHED_PERF_EN
        check("rst_perf", 64'(perf_cycles), 64'd0);
`endif

        // Nominal job.
        run_job(32'h1000, 32'h8000, 32'd64, 32'd256, 2, 1'b0);

        // Join order: in done at cycle 5, reduction done at cycle 9.
        tick();
        set_cfg(32'h1000, 32'h8000, 32'd64, 32'd256, 1);
        start = 1'b1;                                        // cycle 0
        tick();                                              // cycle 1
        check("acc_start_reqs", 64'({strm.in_ctrl_o.req_start, strm.out_ctrl_o.req_start,
                                     dp_phase}), 64'b100);
        check("acc_start_tot_len", 64'(strm.in_ctrl_o.addressgen_ctrl.tot_len), 64'd4);
        for (int c = 2; c <= 9; c++) begin
            tick();
            if (c == 5) d_in = 1'b1;
            if (c == 9) d_acc = 1'b1;
        end
        check("join_c9_no_start", 64'({strm.in_ctrl_o.req_start, strm.out_ctrl_o.req_start}),
              64'd0);
        tick();                                              // cycle 10
        check("join_c10_norm_start", 64'({strm.in_ctrl_o.req_start, strm.out_ctrl_o.req_start,
                                          dp_phase}), 64'b111);
        tick();                                              // cycle 11
        d_in = 1'b1; d_out = 1'b1;
        tick();                                              // cycle 12: next row
        check("next_row_busy", 64'({busy, done}), 64'b10);
        tick();                                              // cycle 13: finish
        check("finish_done", 64'({busy, done}), 64'b11);
        check("finish_row_idx", 64'(row_idx), 64'd1);
        tick();
        check("finish_idle", 64'({busy, done}), 64'b00);

        // Same-cycle join in ACC; staggered join in NORM.
        tick();
        set_cfg(32'h4000, 32'h5000, 32'd32, 32'd64, 1);
        start = 1'b1;                                        // cycle 0
        tick();                                              // cycle 1
        tick();                                              // cycle 2
        d_in = 1'b1; d_acc = 1'b1;
        tick();                                              // cycle 3
        check("same_cycle_norm_start", 64'({strm.in_ctrl_o.req_start,
                                            strm.out_ctrl_o.req_start}), 64'b11);
        check("norm_out_base", 64'(strm.out_ctrl_o.addressgen_ctrl.base_addr), 64'h5000);
        tick();                                              // cycle 4
        d_out = 1'b1;
        tick();                                              // cycle 5
        check("norm_wait_half", 64'({busy, dp_phase, done}), 64'b110);
        d_in = 1'b1;
        repeat (2) tick();                                   // cycle 7
        check("norm_done_pulse", 64'(done), 64'd1);

        // Degenerate configurations: no rows, then empty rows.
        for (int k = 0; k < 2; k++) begin
            tick();
            if (k == 0) set_cfg(32'h100, 32'h200, 32'd64, 32'd64, 0);
            else        set_cfg(32'h100, 32'h200, 32'd0, 32'd64, 3);
            start = 1'b1;
            tick();
            check("degen_finish", 64'({busy, done, strm.in_ctrl_o.req_start,
                                       strm.out_ctrl_o.req_start}), 64'b1100);
            tick();
            check("degen_idle", 64'({busy, done, strm.in_ctrl_o.req_start,
                                     strm.out_ctrl_o.req_start}), 64'b0000);
        end

        // Clear in NORM_WAIT with a competing start, then a late out done.
        tick();
        set_cfg(32'h2000, 32'h6000, 32'd64, 32'd128, 2);
        start = 1'b1;                                        // cycle 0
        repeat (2) tick();                                   // cycle 2
        d_in = 1'b1; d_acc = 1'b1;
        repeat (2) tick();                                   // cycle 4: NORM_WAIT
        d_in = 1'b1;
        tick();                                              // cycle 5
        clear = 1'b1; start = 1'b1;
        tick();                                              // cycle 6
        check("clear_outputs", 64'({busy, done, dp_phase, strm.in_ctrl_o.req_start,
                                    strm.out_ctrl_o.req_start}), 64'd0);
        check("clear_row_idx", 64'(row_idx), 64'd0);
        check("clear_cfg", 64'({strm.in_ctrl_o.addressgen_ctrl.base_addr,
                                strm.in_ctrl_o.addressgen_ctrl.tot_len}), 64'd0);
`ifdef SFM_STREAM_SCHED_PERF_EN
        check("clear_perf", 64'(perf_cycles), 64'd0);
`endif
        d_out = 1'b1;
        tick();
        check("clear_stays_idle", 64'(busy), 64'd0);

        // Follow-up job: stale stickies must not end NORM_WAIT early.
        tick();
        set_cfg(32'h3000, 32'h7000, 32'd64, 32'd128, 1);
        start = 1'b1;                                        // cycle 0
        repeat (2) tick();                                   // cycle 2
        set_cfg(32'h9999_0000, 32'h8888_0000, 32'd16, 32'd16, 5);
        start = 1'b1; d_in = 1'b1; d_acc = 1'b1;
        tick();                                              // cycle 3
        check("busy_start_ignored", 64'(strm.in_ctrl_o.addressgen_ctrl.base_addr), 64'h3000);
        tick();                                              // cycle 4
        d_in = 1'b1;
        tick();                                              // cycle 5
        check("no_stale_sticky", 64'({busy, dp_phase, done}), 64'b110);
        d_out = 1'b1;
        repeat (2) tick();                                   // cycle 7
        check("followup_done", 64'({done, row_idx}), 64'h1_0001);
        tick();

        // Address wrap on the second row.
        run_job(32'hFFFF_FF00, 32'hFFFF_FFF0, 32'd64, 32'h200, 2, 1'b0);

        // Randomized jobs with spurious starts while busy.
        for (int j = 0; j < 25; j++) begin
            logic [31:0] len;
            case ($urandom_range(0, 3))
                0:       len = 32'd0;
                1:       len = $urandom;
                default: len = 32'(16 * $urandom_range(1, 64));
            endcase
            run_job($urandom, $urandom, len, $urandom, int'($urandom_range(0, 4)), 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
